// File: rtl/seg7_pkg.sv
// Shared constants, types and BCD helper for the 7-segment sequence decoder.
// Segment patterns are {g,f,e,d,c,b,a}, active low (common anode).
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK  = 2'd1,
      TRACK = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   // Three-digit BCD increment; 999 rolls over to 000.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd9) begin
            r[7:4] = v[7:4] + 4'd1;
         end else begin
            r[7:4] = 4'd0;
            if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
            else                 r[11:8] = 4'd0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Decodes one active-low segment pattern to a BCD digit; ok=0 for anything outside 0-9.
// Purely combinational, no flow control.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       ok
);

   always_comb begin
      digit = 4'd0;
      ok    = 1'b1;
      case (seg)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: ok    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_seq_decoder.sv
// Decodes three strobed 7-seg digits to BCD and checks for a legal up-count with wrap.
// All outputs register one clk after stb; no backpressure. Optional err_cnt via SEG7_SEQ_DECODER_ERR_CNT_EN.
module seg7_seq_decoder
   import seg7_pkg::*;
#(
   parameter bit          STB_HOLD_OK = 1'b1,
   parameter logic [11:0] MOD_LIMIT   = 12'h999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stb,
   input  logic [6:0]  SG0,
   input  logic [6:0]  SG1,
   input  logic [6:0]  SG2,
   output logic [11:0] num_bcd,
   output logic        num_valid,
   output logic        wrap,
   output logic [11:0] modulus,
   output logic        mod_valid,
   output logic        err_inv,
   output logic        err_seq,
   output logic        err_range,
   output logic        locked
`ifdef SEG7_SEQ_DECODER_ERR_CNT_EN
   ,
   output logic [7:0]  err_cnt
`endif
);

   bcd_digit_t  d0, d1, d2;
   logic        ok0, ok1, ok2;
   logic [11:0] v;
   logic        all_ok;

   seg7_to_bcd u_dec0 (.seg(SG0), .digit(d0), .ok(ok0));
   seg7_to_bcd u_dec1 (.seg(SG1), .digit(d1), .ok(ok1));
   seg7_to_bcd u_dec2 (.seg(SG2), .digit(d2), .ok(ok2));

   assign v      = {d2, d1, d0};
   assign all_ok = ok0 & ok1 & ok2;

   state_t      state_q, state_nxt;
   logic [11:0] num_nxt, mod_nxt;
   logic        mod_vld_nxt;
   logic        nv_nxt, wrap_nxt, inv_nxt, seq_nxt, rng_nxt;

   always_comb begin
      state_nxt   = state_q;
      num_nxt     = num_bcd;
      mod_nxt     = modulus;
      mod_vld_nxt = mod_valid;
      nv_nxt      = 1'b0;
      wrap_nxt    = 1'b0;
      inv_nxt     = 1'b0;
      seq_nxt     = 1'b0;
      rng_nxt     = 1'b0;
      if (stb) begin
         if (!all_ok) begin
            inv_nxt = 1'b1;
         end else begin
            rng_nxt = (v > MOD_LIMIT);
            if (state_q == IDLE) begin
               num_nxt   = v;
               nv_nxt    = 1'b1;
               state_nxt = LOCK;
            end else if (v == num_bcd) begin
               // A held counter shows the same value on consecutive strobes.
               seq_nxt = !STB_HOLD_OK;
            end else if (v == bcd_inc(num_bcd) || v == 12'h000) begin
               num_nxt   = v;
               nv_nxt    = 1'b1;
               state_nxt = TRACK;
               if (v == 12'h000) begin
                  wrap_nxt    = 1'b1;
                  mod_nxt     = num_bcd;
                  mod_vld_nxt = 1'b1;
               end
            end else begin
               num_nxt = v;
               nv_nxt  = 1'b1;
               if (state_q == TRACK) begin
                  seq_nxt   = 1'b1;
                  state_nxt = LOCK;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         num_bcd   <= 12'h000;
         modulus   <= 12'h000;
         mod_valid <= 1'b0;
         num_valid <= 1'b0;
         wrap      <= 1'b0;
         err_inv   <= 1'b0;
         err_seq   <= 1'b0;
         err_range <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         num_bcd   <= num_nxt;
         modulus   <= mod_nxt;
         mod_valid <= mod_vld_nxt;
         num_valid <= nv_nxt;
         wrap      <= wrap_nxt;
         err_inv   <= inv_nxt;
         err_seq   <= seq_nxt;
         err_range <= rng_nxt;
      end
   end

   assign locked = (state_q == TRACK);

`ifdef SEG7_SEQ_DECODER_ERR_CNT_EN
   // Counts on the same edge the error pulse appears, once per cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_cnt <= 8'd0;
      end else if ((inv_nxt | seq_nxt | rng_nxt) && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seg7_seq_decoder.sv
// Scoreboard bench: dut holds repeats legally (limit 999); dut_b flags repeats and has limit 040.
`timescale 1ns/1ps
module tb_seg7_seq_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stb = 1'b0;
   logic [6:0]  SG0 = 7'h7F, SG1 = 7'h7F, SG2 = 7'h7F;

   logic [11:0] num_bcd, modulus, b_num_bcd, b_modulus;
   logic        num_valid, wrap, mod_valid, err_inv, err_seq, err_range, locked;
   logic        b_num_valid, b_wrap, b_mod_valid, b_err_inv, b_err_seq, b_err_range, b_locked;
`ifdef SEG7_SEQ_DECODER_ERR_CNT_EN
   logic [7:0]  err_cnt, b_err_cnt;
`endif

   always #5 clk = ~clk;

   seg7_seq_decoder #(.STB_HOLD_OK(1'b1), .MOD_LIMIT(12'h999)) dut (
      .clk(clk), .rst(rst), .stb(stb), .SG0(SG0), .SG1(SG1), .SG2(SG2),
      .num_bcd(num_bcd), .num_valid(num_valid), .wrap(wrap), .modulus(modulus),
      .mod_valid(mod_valid), .err_inv(err_inv), .err_seq(err_seq),
      .err_range(err_range), .locked(locked)
`ifdef SEG7_SEQ_DECODER_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   seg7_seq_decoder #(.STB_HOLD_OK(1'b0), .MOD_LIMIT(12'h040)) dut_b (
      .clk(clk), .rst(rst), .stb(stb), .SG0(SG0), .SG1(SG1), .SG2(SG2),
      .num_bcd(b_num_bcd), .num_valid(b_num_valid), .wrap(b_wrap), .modulus(b_modulus),
      .mod_valid(b_mod_valid), .err_inv(b_err_inv), .err_seq(b_err_seq),
      .err_range(b_err_range), .locked(b_locked)
`ifdef SEG7_SEQ_DECODER_ERR_CNT_EN
      , .err_cnt(b_err_cnt)
`endif
   );

   typedef struct packed {
      logic [11:0] num;
      logic        nv;
      logic        wr;
      logic [11:0] modv;
      logic        mv;
      logic        inv;
      logic        seq;
      logic        rng;
      logic        lk;
      logic        seq_b;
      logic        rng_b;
   } exp_t;

   exp_t        q[$];
   exp_t        e_m, a_m;
   logic        stb_q = 1'b0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_smp = 0;
   logic [11:0] cur_mod = 12'h000;
   logic        cur_mv = 1'b0;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
         4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
         4'd9: return 7'h10;  default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [11:0] bcd(input int n);
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic [20:0] pat(input logic [11:0] v);
      return {seg_of(v[11:8]), seg_of(v[7:4]), seg_of(v[3:0])};
   endfunction

   function automatic exp_t mk(input logic [11:0] num, input logic nv, input logic wr,
                               input logic [11:0] modv, input logic mv, input logic inv,
                               input logic seq, input logic rng, input logic lk,
                               input logic seq_b, input logic rng_b);
      exp_t e;
      e = '{num, nv, wr, modv, mv, inv, seq, rng, lk, seq_b, rng_b};
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
      n_chk++;
      if (act === ex) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, ex);
   endtask

   task automatic send(input logic [20:0] p, input exp_t e);
      @(posedge clk); #1;
      {SG2, SG1, SG0} = p;
      stb = 1'b1;
      q.push_back(e);
      @(posedge clk); #1;
      stb = 1'b0;
   endtask

   // Straight count from..to in TRACK; dut_b flags anything above 40.
   task automatic sweep(input int from, input int to);
      for (int n = from; n <= to; n++)
         send(pat(bcd(n)), mk(bcd(n), 1, 0, cur_mod, cur_mv, 0, 0, 0, 1, 0, n > 40));
   endtask

   always @(posedge clk) stb_q <= stb;

   always @(negedge clk) begin
      if (stb_q) begin
         n_smp++;
         n_chk++;
         if (q.size() == 0) begin
            $display("FAIL sample#%0d: response with empty scoreboard", n_smp);
         end else begin
            e_m = q.pop_front();
            a_m = '{num_bcd, num_valid, wrap, modulus, mod_valid, err_inv, err_seq,
                    err_range, locked, b_err_seq, b_err_range};
            if (a_m === e_m) n_pass++;
            else $display("FAIL sample#%0d (got/exp) num %h/%h nv %b/%b wrap %b/%b mod %h/%h mv %b/%b inv %b/%b seq %b/%b rng %b/%b lk %b/%b bseq %b/%b brng %b/%b",
                          n_smp, a_m.num, e_m.num, a_m.nv, e_m.nv, a_m.wr, e_m.wr, a_m.modv, e_m.modv,
                          a_m.mv, e_m.mv, a_m.inv, e_m.inv, a_m.seq, e_m.seq, a_m.rng, e_m.rng,
                          a_m.lk, e_m.lk, a_m.seq_b, e_m.seq_b, a_m.rng_b, e_m.rng_b);
         end
      end else if (rst) begin
         n_chk++;
         if ({num_valid, wrap, err_inv, err_seq, err_range, b_err_seq, b_err_range} === 7'b0)
            n_pass++;
         else
            $display("FAIL idle_pulses: got %b expected 0000000",
                     {num_valid, wrap, err_inv, err_seq, err_range, b_err_seq, b_err_range});
      end
   end

   initial begin
      logic [20:0] p;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_num", 32'(num_bcd), 32'h000);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_modulus", 32'(modulus), 32'h000);
      chk("rst_mod_valid", 32'(mod_valid), 32'd0);
      chk("rst_pulses", 32'({num_valid, wrap, err_inv, err_seq, err_range}), 32'd0);
`ifdef SEG7_SEQ_DECODER_ERR_CNT_EN
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
      rst = 1'b1;

      // First sample only locks on; 001 onward tracks, carry at 009->010.
      send(pat(12'h000), mk(12'h000, 1, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0));
      sweep(1, 10);

      // Mod-50 laps: wrap on 000 after 049, twice.
      sweep(11, 49);
      send(pat(12'h000), mk(12'h000, 1, 1, 12'h049, 1, 0, 0, 0, 1, 0, 0));
      cur_mod = 12'h049; cur_mv = 1'b1;
      sweep(1, 49);
      send(pat(12'h000), mk(12'h000, 1, 1, 12'h049, 1, 0, 0, 0, 1, 0, 0));

      // Skip 023->025 drops lock, 026 regains it.
      sweep(1, 23);
      send(pat(12'h025), mk(12'h025, 1, 0, 12'h049, 1, 0, 1, 0, 0, 1, 0));
      send(pat(12'h026), mk(12'h026, 1, 0, 12'h049, 1, 0, 0, 0, 1, 0, 0));

      // Blank tens digit at 099 is ignored apart from err_inv; 100 follows.
      sweep(27, 99);
      p = pat(12'h099);
      p[13:7] = 7'h7F;
      send(p, mk(12'h099, 0, 0, 12'h049, 1, 1, 0, 0, 1, 0, 0));
      send(pat(12'h100), mk(12'h100, 1, 0, 12'h049, 1, 0, 0, 0, 1, 0, 1));

      // Repeats in LOCK and in TRACK.
      send(pat(12'h047), mk(12'h047, 1, 0, 12'h049, 1, 0, 1, 0, 0, 1, 1));
      send(pat(12'h047), mk(12'h047, 0, 0, 12'h049, 1, 0, 0, 0, 0, 1, 1));
      send(pat(12'h048), mk(12'h048, 1, 0, 12'h049, 1, 0, 0, 0, 1, 0, 1));
      send(pat(12'h048), mk(12'h048, 0, 0, 12'h049, 1, 0, 0, 0, 1, 1, 1));

      // Early wrap from 048, then 000 again is a repeat, not a wrap.
      send(pat(12'h000), mk(12'h000, 1, 1, 12'h048, 1, 0, 0, 0, 1, 0, 0));
      send(pat(12'h000), mk(12'h000, 0, 0, 12'h048, 1, 0, 0, 0, 1, 1, 0));

      // Reset wins over a coincident strobe while tracking.
      @(posedge clk); #1;
      {SG2, SG1, SG0} = pat(12'h005);
      stb = 1'b1;
      rst = 1'b0;
      q.push_back(mk(12'h000, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      stb = 1'b0;
      rst = 1'b1;
      cur_mod = 12'h000; cur_mv = 1'b0;
      send(pat(12'h007), mk(12'h007, 1, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0));
      send(pat(12'h008), mk(12'h008, 1, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0));

`ifdef SEG7_SEQ_DECODER_ERR_CNT_EN
      @(negedge clk);
      chk("err_cnt_after_reset", 32'(err_cnt), 32'd0);
      for (int i = 0; i < 300; i++)
         send(21'h1FFFFF, mk(12'h008, 0, 0, 12'h000, 0, 1, 0, 0, 1, 0, 0));
      @(negedge clk);
      chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
